// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge with three decoded peripheral slots.
// Writes spend one wait cycle to collect data; back-to-back writes use the pipelined P states.
module ahb2apb_bridge (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Penable,
    output logic        Pwrite,
    output logic [2:0]  Pselx,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    state_t      r_state;
    logic [31:0] r_haddr_p1;
    logic [31:0] r_haddr_p2;
    logic        r_hwrite_p1;

    logic        w_valid;
    logic [31:0] w_wr_addr;
    logic        w_unused;

    // Each slot occupies a 64 MB window starting at 0x8000_0000.
    function automatic logic [2:0] decode_slot(input logic [31:0] addr);
        case (addr[31:26])
            6'b100000: decode_slot = 3'b001;
            6'b100001: decode_slot = 3'b010;
            6'b100010: decode_slot = 3'b100;
            default:   decode_slot = 3'b000;
        endcase
    endfunction

    assign w_valid   = Hreadyin && Htrans[1] &&
                       (Haddr >= 32'h8000_0000) && (Haddr < 32'h8C00_0000);
    // A pipelined write has already seen the next address phase, so its own address is two back.
    assign w_wr_addr = (r_state == ST_WENABLEP) ? r_haddr_p2 : r_haddr_p1;
    assign w_unused  = Htrans[0];

    assign Hresp  = 2'b00;
    assign Hrdata = Prdata;

    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            r_state     <= ST_IDLE;
            r_haddr_p1  <= 32'h0;
            r_haddr_p2  <= 32'h0;
            r_hwrite_p1 <= 1'b0;
            Penable     <= 1'b0;
            Pwrite      <= 1'b0;
            Pselx       <= 3'b000;
            Paddr       <= 32'h0;
            Pwdata      <= 32'h0;
            Hreadyout   <= 1'b1;
        end else begin
            r_haddr_p1  <= Haddr;
            r_haddr_p2  <= r_haddr_p1;
            r_hwrite_p1 <= Hwrite;
            case (r_state)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    if (w_valid && !Hwrite) begin
                        r_state   <= ST_READ;
                        Paddr     <= Haddr;
                        Pselx     <= decode_slot(Haddr);
                        Pwrite    <= 1'b0;
                        Penable   <= 1'b0;
                        Hreadyout <= 1'b0;
                    end else begin
                        r_state   <= (w_valid && Hwrite) ? ST_WWAIT : ST_IDLE;
                        Penable   <= 1'b0;
                        Pselx     <= 3'b000;
                        Hreadyout <= 1'b1;
                    end
                end
                ST_WWAIT: begin
                    r_state   <= w_valid ? ST_WRITEP : ST_WRITE;
                    Paddr     <= w_wr_addr;
                    Pwdata    <= Hwdata;
                    Pselx     <= decode_slot(w_wr_addr);
                    Pwrite    <= 1'b1;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                ST_READ: begin
                    r_state   <= ST_RENABLE;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                ST_WRITE: begin
                    r_state   <= w_valid ? ST_WENABLEP : ST_WENABLE;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                ST_WRITEP: begin
                    r_state   <= ST_WENABLEP;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                ST_WENABLEP: begin
                    if (!r_hwrite_p1) begin
                        r_state   <= ST_READ;
                        Paddr     <= Haddr;
                        Pselx     <= decode_slot(Haddr);
                        Pwrite    <= 1'b0;
                        Penable   <= 1'b0;
                        Hreadyout <= 1'b0;
                    end else begin
                        r_state   <= w_valid ? ST_WRITEP : ST_WRITE;
                        Paddr     <= w_wr_addr;
                        Pwdata    <= Hwdata;
                        Pselx     <= decode_slot(w_wr_addr);
                        Pwrite    <= 1'b1;
                        Penable   <= 1'b0;
                        Hreadyout <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    Penable   <= 1'b0;
                    Pselx     <= 3'b000;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed test-plan sequences plus random traffic,
// all compared against a transition-table reference model of the bridge.
module tb_ahb2apb_bridge;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Penable;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    ahb2apb_bridge dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
        .Penable(Penable), .Pwrite(Pwrite), .Pselx(Pselx), .Paddr(Paddr),
        .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int S_IDLE = 0, S_WWAIT = 1, S_READ = 2, S_WRITE = 3,
                   S_WRITEP = 4, S_RENABLE = 5, S_WENABLE = 6, S_WENABLEP = 7;

    int          m_state;
    logic [31:0] m_a1, m_a2;
    logic        m_w1;
    logic [31:0] e_paddr, e_pwdata;
    logic        e_pwrite, e_pen, e_hr;
    logic [2:0]  e_psel;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8C00_0000);
    endfunction

    function automatic logic [2:0] slot_of(input logic [31:0] a);
        logic [31:0] idx;
        if (!in_range(a)) return 3'b000;
        idx = (a - 32'h8000_0000) / 32'h0400_0000;
        return 3'b001 << idx[1:0];
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_a1 = 0; m_a2 = 0; m_w1 = 0;
        e_paddr = 0; e_pwdata = 0; e_pwrite = 0; e_pen = 0; e_hr = 1; e_psel = 0;
    endtask

    task automatic model_step(input logic [1:0] tr, input logic wr, input logic [31:0] ad,
                              input logic [31:0] wd, input logic rdy);
        logic        v;
        int          nxt;
        logic [31:0] src;
        v   = rdy && tr[1] && in_range(ad);
        nxt = S_IDLE;
        case (m_state)
            S_IDLE, S_RENABLE, S_WENABLE: nxt = !v ? S_IDLE : (wr ? S_WWAIT : S_READ);
            S_WWAIT:    nxt = v ? S_WRITEP : S_WRITE;
            S_READ:     nxt = S_RENABLE;
            S_WRITE:    nxt = v ? S_WENABLEP : S_WENABLE;
            S_WRITEP:   nxt = S_WENABLEP;
            S_WENABLEP: nxt = !m_w1 ? S_READ : (v ? S_WRITEP : S_WRITE);
            default:    nxt = S_IDLE;
        endcase
        if (nxt == S_READ) begin
            e_paddr = ad; e_psel = slot_of(ad); e_pwrite = 0; e_pen = 0; e_hr = 0;
        end else if (nxt == S_WRITE || nxt == S_WRITEP) begin
            src = (m_state == S_WENABLEP) ? m_a2 : m_a1;
            e_paddr = src; e_pwdata = wd; e_psel = slot_of(src);
            e_pwrite = 1; e_pen = 0; e_hr = 0;
        end else if (nxt == S_RENABLE || nxt == S_WENABLE || nxt == S_WENABLEP) begin
            e_pen = 1; e_hr = 1;
        end else begin
            e_pen = 0; e_psel = 0; e_hr = 1;
        end
        m_a2 = m_a1; m_a1 = ad; m_w1 = wr; m_state = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pselx",     32'(Pselx),     32'(e_psel));
        chk("penable",   32'(Penable),   32'(e_pen));
        chk("pwrite",    32'(Pwrite),    32'(e_pwrite));
        chk("paddr",     Paddr,          e_paddr);
        chk("pwdata",    Pwdata,         e_pwdata);
        chk("hreadyout", 32'(Hreadyout), 32'(e_hr));
        chk("hresp",     32'(Hresp),     32'h0);
        chk("hrdata",    Hrdata,         Prdata);
    endtask

    task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] ad,
                         input logic [31:0] wd, input logic rdy, input logic [31:0] rd);
        Htrans = tr; Hwrite = wr; Haddr = ad; Hwdata = wd; Hreadyin = rdy; Prdata = rd;
        @(posedge Hclk);
        model_step(tr, wr, ad, wd, rdy);
        #1;
        check_model();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFC;
            1: return 32'h8BFF_FFFC;
            2: return 32'h8C00_0000;
            3: return 32'h9000_0000;
            4: return r;
            default: return 32'h8000_0000 + {4'h0, r[27:2], 2'b00} % 32'h0C00_0000;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        Hresetn = 1'b1; Hwrite = 0; Hreadyin = 1; Htrans = 2'b00;
        Haddr = 0; Hwdata = 0; Prdata = 32'hDEAD_BEEF;
        model_reset();
        #2;
        chk("rst_pselx",   32'(Pselx),     32'h0);
        chk("rst_penable", 32'(Penable),   32'h0);
        chk("rst_hready",  32'(Hreadyout), 32'h1);
        chk("rst_hresp",   32'(Hresp),     32'h0);
        @(negedge Hclk);
        Hresetn = 1'b0;

        // Single write
        drive(2'b10, 1, 32'h8000_0000, 32'h0, 1, 32'h0);
        drive(2'b00, 0, 32'h0, 32'hA5A5_A5A5, 1, 32'h0);
        chk("wr_pselx",  32'(Pselx), 32'h1);
        chk("wr_pwrite", 32'(Pwrite), 32'h1);
        chk("wr_paddr",  Paddr, 32'h8000_0000);
        chk("wr_pwdata", Pwdata, 32'hA5A5_A5A5);
        chk("wr_pen0",   32'(Penable), 32'h0);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("wr_pen1",   32'(Penable), 32'h1);
        chk("wr_hready", 32'(Hreadyout), 32'h1);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);

        // Single read
        drive(2'b10, 0, 32'h8400_0010, 32'h0, 1, 32'h1234_5678);
        chk("rd_pselx",  32'(Pselx), 32'h2);
        chk("rd_pwrite", 32'(Pwrite), 32'h0);
        chk("rd_hready", 32'(Hreadyout), 32'h0);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h1234_5678);
        chk("rd_pen",    32'(Penable), 32'h1);
        chk("rd_hready1", 32'(Hreadyout), 32'h1);
        chk("rd_hrdata", Hrdata, 32'h1234_5678);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);

        // Burst read: each later beat is held through the stalled setup cycle
        drive(2'b10, 0, 32'h8800_0000, 32'h0, 1, $urandom);
        chk("brd_paddr0", Paddr, 32'h8800_0000);
        for (int b = 1; b < 4; b++) begin
            a = 32'h8800_0000 + 32'(b * 4);
            drive(2'b11, 0, a, 32'h0, 1, $urandom);
            chk("brd_pen", 32'(Penable), 32'h1);
            chk("brd_sel_en", 32'(Pselx), 32'h4);
            drive(2'b11, 0, a, 32'h0, 1, $urandom);
            chk("brd_paddr", Paddr, a);
            chk("brd_sel_su", 32'(Pselx), 32'h4);
        end
        drive(2'b00, 0, 32'h0, 32'h0, 1, $urandom);
        chk("brd_last_en", 32'(Penable), 32'h1);
        drive(2'b00, 0, 32'h0, 32'h0, 1, $urandom);

        // Burst write: data lags its address by one beat
        drive(2'b10, 1, 32'h8000_0000, 32'h0, 1, 32'h0);
        for (int b = 1; b <= 4; b++) begin
            a = 32'h8000_0000 + 32'(b * 4);
            d = 32'hC0DE_0000 + 32'(b - 1);
            drive((b < 4) ? 2'b11 : 2'b00, b < 4, (b < 4) ? a : 32'h0, d, 1, 32'h0);
            chk("bwr_paddr",  Paddr, a - 32'h4);
            chk("bwr_pwdata", Pwdata, d);
            chk("bwr_pwrite", 32'(Pwrite), 32'h1);
            drive((b < 4) ? 2'b11 : 2'b00, b < 4, (b < 4) ? a : 32'h0, d, 1, 32'h0);
            chk("bwr_pen", 32'(Penable), 32'h1);
        end
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);

        // Out of range and BUSY produce no APB activity
        drive(2'b10, 0, 32'h9000_0000, 32'h0, 1, 32'h0);
        chk("oor_pselx", 32'(Pselx), 32'h0);
        chk("oor_hready", 32'(Hreadyout), 32'h1);
        drive(2'b01, 1, 32'h8000_0000, 32'h0, 1, 32'h0);
        chk("busy_pselx", 32'(Pselx), 32'h0);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("busy_hready", 32'(Hreadyout), 32'h1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(2'($urandom), 1'($urandom), pick_addr(), $urandom,
                  ($urandom_range(0, 7) != 0), $urandom);
        end
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);

        // Reset asserted during a read enable phase
        drive(2'b10, 0, 32'h8400_0000, 32'h0, 1, 32'h0);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h0);
        chk("mrst_pre_pen", 32'(Penable), 32'h1);
        #2;
        Hresetn = 1'b1;
        #1;
        chk("mrst_pen",   32'(Penable), 32'h0);
        chk("mrst_pselx", 32'(Pselx), 32'h0);
        chk("mrst_hready", 32'(Hreadyout), 32'h1);
        chk("mrst_paddr", Paddr, 32'h0);
        chk("mrst_pwdata", Pwdata, 32'h0);
        chk("mrst_pwrite", 32'(Pwrite), 32'h0);
        model_reset();
        @(negedge Hclk);
        Hresetn = 1'b0;
        drive(2'b10, 0, 32'h8800_0004, 32'h0, 1, 32'h5555_AAAA);
        drive(2'b00, 0, 32'h0, 32'h0, 1, 32'h5555_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
